// File: rtl/imem_prog.sv
// Writable instruction memory: clear sweep after reset, streaming program loader and one-cycle fetch with stall.
// Optional IMEM_PARITY_EN stores an even-parity bit per word and flags mismatches on fetch responses.
module imem_prog #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 256,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_pc,
   input  logic              fetch_stall,
   output logic              fetch_ready,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              addr_fault,
   input  logic              prog_start,
   input  logic [ADDR_W-1:0] prog_base,
   input  logic              prog_valid,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              prog_done,
   output logic              prog_overflow,
   output logic              parity_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  clr_cnt_q;
   logic [ADDR_W:0]   wptr_q;
   logic [DATA_W-1:0] instr_q;
   logic              instr_valid_q;
   logic              addr_fault_q;
   logic              overflow_q;
   logic              parity_err_q;
   logic              fetch_ready_q;

   logic [MEM_W-1:0]  mem [DEPTH];
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [MEM_W-1:0]  mem_wdata;
   logic [MEM_W-1:0]  rdata;
   logic              rd_perr;
   logic              pc_in_range;
   logic              wptr_in_range;

   function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef IMEM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   assign pc_in_range   = ({1'b0, fetch_pc} < DEPTH_X);
   assign wptr_in_range = (wptr_q < DEPTH_X);
   assign rdata         = mem[fetch_pc[IDX_W-1:0]];

`ifdef IMEM_PARITY_EN
   // Stored bit equals data parity, so the XOR over the whole entry is the mismatch.
   assign rd_perr = ^rdata;
`else
   assign rd_perr = 1'b0;
`endif

   // Single write port shared by the clear sweep and the loader.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_cnt_q;
      mem_wdata = encode(NOP_WORD);
      case (state_q)
         ST_CLEAR: mem_we = 1'b1;
         ST_LOAD: begin
            if (!prog_start && prog_valid && wptr_in_range) begin
               mem_we    = 1'b1;
               mem_waddr = wptr_q[IDX_W-1:0];
               mem_wdata = encode(prog_data);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_CLEAR;
         clr_cnt_q     <= '0;
         wptr_q        <= '0;
         instr_q       <= NOP_WORD;
         instr_valid_q <= 1'b0;
         addr_fault_q  <= 1'b0;
         overflow_q    <= 1'b0;
         parity_err_q  <= 1'b0;
         fetch_ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (clr_cnt_q == LAST_IDX) begin
                  clr_cnt_q     <= '0;
                  state_q       <= ST_RUN;
                  fetch_ready_q <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (prog_start) begin
                  state_q       <= ST_LOAD;
                  wptr_q        <= {1'b0, prog_base};
                  overflow_q    <= 1'b0;
                  fetch_ready_q <= 1'b0;
                  instr_valid_q <= 1'b0;
               end else if (!fetch_stall) begin
                  if (fetch_req) begin
                     instr_valid_q <= 1'b1;
                     if (pc_in_range) begin
                        instr_q      <= rdata[DATA_W-1:0];
                        addr_fault_q <= 1'b0;
                        parity_err_q <= rd_perr;
                     end else begin
                        instr_q      <= NOP_WORD;
                        addr_fault_q <= 1'b1;
                        parity_err_q <= 1'b0;
                     end
                  end else begin
                     instr_valid_q <= 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               instr_valid_q <= 1'b0;
               if (prog_start) begin
                  wptr_q <= {1'b0, prog_base};
               end else begin
                  if (prog_valid) begin
                     if (wptr_in_range) wptr_q <= wptr_q + 1'b1;
                     else               overflow_q <= 1'b1;
                  end
                  if (prog_done) begin
                     state_q       <= ST_RUN;
                     fetch_ready_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_CLEAR;
         endcase
      end
   end

   assign fetch_ready   = fetch_ready_q;
   assign instr         = instr_q;
   assign instr_valid   = instr_valid_q;
   assign addr_fault    = addr_fault_q;
   assign prog_overflow = overflow_q;
   assign parity_err    = parity_err_q;

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog: clear sweep, loading, faults, stall, overflow and reset during load.
`timescale 1ns/1ps
module tb_imem_prog;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req;
   logic [15:0] fetch_pc;
   logic        fetch_stall;
   logic        fetch_ready;
   logic [15:0] instr;
   logic        instr_valid;
   logic        addr_fault;
   logic        prog_start;
   logic [15:0] prog_base;
   logic        prog_valid;
   logic [15:0] prog_data;
   logic        prog_done;
   logic        prog_overflow;
   logic        parity_err;

   int total  = 0;
   int passed = 0;

   imem_prog dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
      .fetch_ready(fetch_ready), .instr(instr), .instr_valid(instr_valid),
      .addr_fault(addr_fault),
      .prog_start(prog_start), .prog_base(prog_base), .prog_valid(prog_valid),
      .prog_data(prog_data), .prog_done(prog_done),
      .prog_overflow(prog_overflow), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until fetch_ready rises, bounded.
   task automatic wait_ready(output int n);
      n = 0;
      while (!fetch_ready && n < 400) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0; fetch_req = 1'b0; fetch_pc = '0; fetch_stall = 1'b0;
      prog_start = 1'b0; prog_base = '0; prog_valid = 1'b0; prog_data = '0; prog_done = 1'b0;
      #23;
      total++; if ({fetch_ready, instr_valid, addr_fault, prog_overflow, parity_err} !== 5'b0)
         $display("FAIL reset_flags got %b expected 00000",
                  {fetch_ready, instr_valid, addr_fault, prog_overflow, parity_err});
      else passed++;
      total++; if (instr !== 16'h0000) $display("FAIL reset_instr got %h expected 0000", instr);
      else passed++;
      @(posedge clk); #1;
      rst_n = 1'b1; fetch_req = 1'b1; fetch_pc = 16'h0000;
      wait_ready(n);
      total++; if (n !== 256) $display("FAIL clear_cycles got %0d expected 256", n);
      else passed++;
      total++; if (instr_valid !== 1'b0) $display("FAIL clear_ignores_req got %b expected 0", instr_valid);
      else passed++;
      tick();
      $display("fetch pc=%h instr=%h valid=%b fault=%b", fetch_pc, instr, instr_valid, addr_fault);
      total++; if ({instr, instr_valid, addr_fault} !== {16'h0000, 1'b1, 1'b0})
         $display("FAIL first_fetch got %h/%b/%b expected 0000/1/0", instr, instr_valid, addr_fault);
      else passed++;
   endtask

   task automatic test_program_load();
      logic [15:0] words [4];
      words[0] = 16'h2003; words[1] = 16'h2004; words[2] = 16'h2002; words[3] = 16'h8014;
      prog_start = 1'b1; prog_base = 16'h0000;
      tick();
      prog_start = 1'b0;
      total++; if ({fetch_ready, instr_valid} !== 2'b00)
         $display("FAIL load_entry got ready=%b valid=%b expected 0/0", fetch_ready, instr_valid);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         prog_valid = 1'b1; prog_data = words[i]; prog_done = (i == 3);
         tick();
         $display("load word=%h", words[i]);
      end
      prog_valid = 1'b0; prog_done = 1'b0; fetch_req = 1'b0;
      total++; if ({fetch_ready, instr_valid} !== 2'b10)
         $display("FAIL load_exit got ready=%b valid=%b expected 1/0", fetch_ready, instr_valid);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         fetch_req = 1'b1; fetch_pc = 16'(i);
         tick();
         $display("fetch pc=%h instr=%h valid=%b fault=%b", fetch_pc, instr, instr_valid, addr_fault);
         total++; if ({instr, instr_valid, addr_fault} !== {words[i], 1'b1, 1'b0})
            $display("FAIL load_fetch%0d got %h/%b/%b expected %h/1/0", i, instr, instr_valid, addr_fault, words[i]);
         else passed++;
      end
      total++; if (parity_err !== 1'b0) $display("FAIL parity_clean got %b expected 0", parity_err);
      else passed++;
      fetch_req = 1'b0;
      tick();
      total++; if ({instr, instr_valid} !== {16'h8014, 1'b0})
         $display("FAIL idle_hold got %h/%b expected 8014/0", instr, instr_valid);
      else passed++;
   endtask

   task automatic test_fault();
      fetch_req = 1'b1; fetch_pc = 16'h0100;
      tick();
      $display("fetch pc=%h instr=%h valid=%b fault=%b", fetch_pc, instr, instr_valid, addr_fault);
      total++; if ({instr, instr_valid, addr_fault} !== {16'h0000, 1'b1, 1'b1})
         $display("FAIL fault_0100 got %h/%b/%b expected 0000/1/1", instr, instr_valid, addr_fault);
      else passed++;
      fetch_pc = 16'hFFFF;
      tick();
      total++; if ({instr, addr_fault} !== {16'h0000, 1'b1})
         $display("FAIL fault_ffff got %h/%b expected 0000/1", instr, addr_fault);
      else passed++;
      fetch_pc = 16'h00FF;
      tick();
      total++; if ({instr, addr_fault} !== {16'h0000, 1'b0})
         $display("FAIL last_in_range got %h/%b expected 0000/0", instr, addr_fault);
      else passed++;
   endtask

   task automatic test_stall();
      fetch_req = 1'b1; fetch_pc = 16'h0001;
      tick();
      fetch_pc = 16'h0002; fetch_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if ({instr, instr_valid} !== {16'h2004, 1'b1})
            $display("FAIL stall_hold%0d got %h/%b expected 2004/1", i, instr, instr_valid);
         else passed++;
      end
      fetch_stall = 1'b0;
      tick();
      $display("fetch pc=%h instr=%h valid=%b fault=%b", fetch_pc, instr, instr_valid, addr_fault);
      total++; if ({instr, instr_valid} !== {16'h2002, 1'b1})
         $display("FAIL stall_release got %h/%b expected 2002/1", instr, instr_valid);
      else passed++;
   endtask

   task automatic test_overflow();
      fetch_req = 1'b0;
      prog_start = 1'b1; prog_base = 16'd254;
      tick();
      prog_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         prog_valid = 1'b1; prog_data = 16'h1111 * 16'(i + 1);
         tick();
      end
      prog_valid = 1'b0;
      total++; if (prog_overflow !== 1'b1) $display("FAIL overflow_set got %b expected 1", prog_overflow);
      else passed++;
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      total++; if (prog_overflow !== 1'b1) $display("FAIL overflow_sticky_load got %b expected 1", prog_overflow);
      else passed++;
      prog_done = 1'b1;
      tick();
      prog_done = 1'b0;
      fetch_req = 1'b1; fetch_pc = 16'd254;
      tick();
      total++; if (instr !== 16'h1111) $display("FAIL ovf_mem254 got %h expected 1111", instr);
      else passed++;
      fetch_pc = 16'd255;
      tick();
      total++; if (instr !== 16'h2222) $display("FAIL ovf_mem255 got %h expected 2222", instr);
      else passed++;
      fetch_pc = 16'd0;
      tick();
      total++; if ({instr, prog_overflow} !== {16'h2003, 1'b1})
         $display("FAIL ovf_no_wrap got %h/%b expected 2003/1", instr, prog_overflow);
      else passed++;
      fetch_req = 1'b0; prog_start = 1'b1; prog_base = 16'd10;
      tick();
      prog_start = 1'b0;
      total++; if (prog_overflow !== 1'b0) $display("FAIL overflow_clear got %b expected 0", prog_overflow);
      else passed++;
      prog_done = 1'b1;
      tick();
      prog_done = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      int n;
      prog_start = 1'b1; prog_base = 16'd255;
      tick();
      prog_start = 1'b0;
      prog_valid = 1'b1; prog_data = 16'hBEEF;
      tick();
      prog_data = 16'hCAFE;
      tick();
      prog_valid = 1'b0;
      total++; if ({prog_overflow, instr} !== {1'b1, 16'h2003})
         $display("FAIL pre_reset got %b/%h expected 1/2003", prog_overflow, instr);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if ({fetch_ready, instr_valid, addr_fault, prog_overflow, parity_err, instr} !== {5'b0, 16'h0000})
         $display("FAIL async_reset got %b/%h expected 00000/0000",
                  {fetch_ready, instr_valid, addr_fault, prog_overflow, parity_err}, instr);
      else passed++;
      @(posedge clk); #1;
      rst_n = 1'b1; fetch_req = 1'b1; fetch_pc = 16'd255;
      wait_ready(n);
      total++; if (n !== 256) $display("FAIL reclear_cycles got %0d expected 256", n);
      else passed++;
      tick();
      total++; if ({instr, instr_valid, addr_fault} !== {16'h0000, 1'b1, 1'b0})
         $display("FAIL reclear_255 got %h/%b/%b expected 0000/1/0", instr, instr_valid, addr_fault);
      else passed++;
      fetch_pc = 16'd0;
      tick();
      total++; if (instr !== 16'h0000) $display("FAIL reclear_0 got %h expected 0000", instr);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_program_load();
      test_fault();
      test_stall();
      test_overflow();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
